// File: rtl/gcd_controller.sv
// Control FSM for the subtractive GCD datapath: load, compare/subtract loop,
// result capture, with start/busy/done handshake, abort and iteration limit.
module gcd_controller #(
  parameter int unsigned          CNT_W    = 16,
  parameter logic [CNT_W-1:0]     MAX_ITER = CNT_W'(16'hFFFF)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic             eq_flag,
  input  logic             if_flag,
  output logic             x_sel,
  output logic             y_sel,
  output logic             x_load,
  output logic             y_load,
  output logic             gcd_load,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CMP   = 3'd2,
    SUBX  = 3'd3,
    SUBY  = 3'd4,
    STORE = 3'd5,
    DONE  = 3'd6,
    ERR   = 3'd7
  } state_t;

  state_t state, state_nx;

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:  if (start) state_nx = LOAD;
        LOAD:  state_nx = CMP;
        CMP: begin
          if (eq_flag)                  state_nx = STORE;
          else if (iter_count == MAX_ITER) state_nx = ERR;
          else if (if_flag)             state_nx = SUBY;
          else                          state_nx = SUBX;
        end
        SUBX:  state_nx = CMP;
        SUBY:  state_nx = CMP;
        STORE: state_nx = DONE;
        DONE:  state_nx = IDLE;
        ERR:   state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // A subtract step aborted mid-cycle still counts: its load strobe was
  // already asserted, so the datapath register updates on that same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      iter_count <= '0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: if (!abort) iter_count <= '0;
        SUBX, SUBY: if (iter_count != '1) iter_count <= iter_count + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    x_sel    = 1'b0;
    y_sel    = 1'b0;
    x_load   = 1'b0;
    y_load   = 1'b0;
    gcd_load = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    busy     = (state != IDLE);
    case (state)
      LOAD: begin
        x_load = 1'b1;
        y_load = 1'b1;
      end
      SUBX: begin
        x_sel  = 1'b1;
        x_load = 1'b1;
      end
      SUBY: begin
        y_sel  = 1'b1;
        y_load = 1'b1;
      end
      STORE: gcd_load = 1'b1;
      DONE:  done = 1'b1;
      ERR: begin
        done  = 1'b1;
        error = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Scoreboard bench for gcd_controller driving a small live GCD datapath;
// expectations come from a plain subtractive-Euclid reference model.
module tb_gcd_controller;

  localparam int unsigned CNT_W = 16;
  localparam int unsigned MAXI  = 40;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic eq_flag, if_flag;
  logic x_sel, y_sel, x_load, y_load, gcd_load, busy, done, error;
  logic [CNT_W-1:0] iter_count;

  always #5 clk = ~clk;

  gcd_controller #(.CNT_W(CNT_W), .MAX_ITER(16'd40)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .eq_flag(eq_flag), .if_flag(if_flag),
    .x_sel(x_sel), .y_sel(y_sel), .x_load(x_load), .y_load(y_load),
    .gcd_load(gcd_load), .busy(busy), .done(done), .error(error),
    .iter_count(iter_count)
  );

  // Datapath the controller steers
  logic [15:0] a_op = '0, b_op = '0, x_r = '0, y_r = '0, gcd_r = '0;
  assign eq_flag = (x_r == y_r);
  assign if_flag = (x_r < y_r);
  always @(posedge clk) begin
    if (x_load) x_r <= x_sel ? x_r - y_r : a_op;
    if (y_load) y_r <= y_sel ? y_r - x_r : b_op;
    if (gcd_load) gcd_r <= x_r;
  end

  typedef struct {
    int unsigned g;
    int unsigned steps;
    bit          err;
    int unsigned lat;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int load_cyc = 0;
  logic busy_q = 1'b0;
  logic done_q = 1'b0;

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t model(input int unsigned a, input int unsigned b);
    exp_t e;
    int unsigned s = 0;
    while (a != b && s < MAXI) begin
      if (a > b) a = a - b;
      else       b = b - a;
      s++;
    end
    e.err   = (a != b);
    e.g     = a;
    e.steps = s;
    // cycles from the LOAD cycle to the done cycle
    e.lat   = e.err ? 2 + 2 * s : 3 + 2 * s;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops an expectation at every done pulse
  always @(negedge clk) begin
    if (reset) begin
      if (busy && !busy_q) load_cyc = cyc;
      if (gcd_load && (sb.size() == 0 || sb[0].err))
        chk("unexpected_gcd_load", 1, 0);
      if (error && !done) chk("error_without_done", 1, 0);
      if (done && done_q) chk("done_not_pulse", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("error_flag", error, e.err);
          chk("iter_count", iter_count, e.steps);
          chk("latency", cyc - load_cyc, e.lat);
          if (!e.err) chk("gcd", gcd_r, e.g);
        end
      end
    end
    busy_q = busy;
    done_q = done;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    wait_idle();
    a_op = a;
    b_op = b;
    sb.push_back(model(a, b));
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || busy) begin
      chk("done_timeout", 1, 0);
      sb.delete();
    end
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {x_sel, y_sel, x_load, y_load, gcd_load, busy, done, error}, 0);
    chk({name, "_iter"}, iter_count, 0);
  endtask

  initial begin
    int k;
    int n;
    logic [15:0] ra, rb;

    #7 chk_quiet("reset_state");
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_quiet("post_reset_idle");

    // Directed cases: typical, equal, zero operands, iteration-limit boundary
    launch(161, 14); wait_done();
    launch(9, 9);    wait_done();
    launch(5, 0);    wait_done();
    launch(0, 5);    wait_done();
    launch(0, 0);    wait_done();
    launch(41, 1);   wait_done();
    launch(42, 1);   wait_done();

    // Abort in the third SUBX; the aborted step still counts
    launch(161, 14);
    k = 0;
    n = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (x_load && x_sel) k++;
    end
    abort = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_iter", iter_count, 3);
    repeat (3) @(negedge clk);
    chk("abort_no_restart", busy, 0);
    launch(161, 14); wait_done();

    // abort together with start in IDLE: abort wins
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", busy, 0);

    // Asynchronous reset between edges mid-run
    launch(161, 14);
    repeat (9) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_quiet("async_reset_mid_run");
    sb.delete();
    @(negedge clk) reset = 1'b1;
    launch(161, 14); wait_done();

    // start held high: three back-to-back runs
    @(negedge clk);
    a_op = 9;
    b_op = 9;
    for (int i = 0; i < 3; i++) sb.push_back(model(9, 9));
    start = 1'b1;
    k = 0;
    n = 0;
    while (k < 3 && n < 200) begin
      @(negedge clk);
      n++;
      if (done) k++;
    end
    start = 1'b0;
    if (k < 3) chk("held_start_runs", k, 3);
    wait_done();

    // start toggling while busy must not restart
    launch(161, 14);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = ~start;
    end
    start = 1'b0;
    wait_done();

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom_range(0, 63));
      rb = 16'($urandom_range(0, 63));
      launch(ra, rb);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
      wait_done();
    end

    repeat (3) @(negedge clk);
    chk("leftover_expectations", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gcd_controller.md
Name: gcd_controller

Overview:
- Control FSM that sequences the GCD datapath: operand load, repeated subtraction, result capture.
- Observes the datapath comparison flags (eq_flag, if_flag) and drives its mux selects and register loads.
- Gives the system a start/busy/done handshake, an abort input, and an iteration-limit error.
- Sits between the top-level/host logic and the datapath; it has no data-width dependency.

Parameters:
- CNT_W, 16, width of the iteration counter.
- MAX_ITER, 16'hFFFF, maximum subtract steps before the error exit. Must fit in CNT_W bits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request a GCD run; sampled only in IDLE.
- abort  in  1  synchronous cancel; takes priority in every state.
- eq_flag  in  1  datapath: x == y.
- if_flag  in  1  datapath: x < y.
- x_sel  out  1  0 = x mux takes operand a; 1 = x mux takes x-y.
- y_sel  out  1  0 = y mux takes operand b; 1 = y mux takes y-x.
- x_load  out  1  x register load enable.
- y_load  out  1  y register load enable.
- gcd_load  out  1  gcd output register load enable.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  one-cycle pulse together with done on an iteration-limit exit.
- iter_count  out  CNT_W  number of subtract steps in the current or last run.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE; iter_count=0; all control outputs, busy, done and error are 0 immediately.
- Outputs are a Moore decode of the state register. Flags are sampled only in CMP.
- States and outputs (any output not listed is 0):
  - IDLE: all outputs 0. If start=1 and abort=0, go to LOAD.
  - LOAD: x_sel=0, y_sel=0, x_load=1, y_load=1; iter_count cleared to 0 on exit. Go to CMP.
  - CMP: no loads. Transitions in priority order:
    - eq_flag=1 -> STORE.
    - iter_count==MAX_ITER -> ERR.
    - if_flag=1 -> SUBY.
    - otherwise -> SUBX.
  - SUBX: x_sel=1, x_load=1; iter_count+1 (saturating at all-ones). Go to CMP.
  - SUBY: y_sel=1, y_load=1; iter_count+1 (saturating at all-ones). Go to CMP.
  - STORE: gcd_load=1. Go to DONE.
  - DONE: done=1 for one cycle. Go to IDLE.
  - ERR: done=1, error=1 for one cycle, gcd_load never asserted. Go to IDLE.
- busy=1 in LOAD, CMP, SUBX, SUBY, STORE, DONE and ERR.
- Latency: a run with N subtract steps takes 4+2N cycles from the start-accept edge to the done cycle inclusive (LOAD, CMP, N×(SUB,CMP), STORE, DONE).
- Flags are ignored outside CMP. eq_flag wins over if_flag if both are high.
- start while busy is ignored. start held high through DONE begins a new run on the following IDLE cycle, with at least one IDLE cycle between runs.
- abort=1 on any edge forces IDLE next cycle:
  - no gcd_load and no done are issued;
  - iter_count keeps its value;
  - abort and start together in IDLE: abort wins.
- Zero operand (x or y = 0) never converges. It is terminated by the MAX_ITER -> ERR path.
- iter_count holds after DONE/ERR and is cleared only on LOAD exit or by reset.
- Reset asserted mid-run: immediate return to IDLE, all outputs 0, no done pulse.

Test Plan:
- a=161, b=14 driven to a live datapath, start pulsed 1 cycle:
  - 11 SUBX then 1 SUBY; iter_count=12;
  - gcd_load in cycle 27 and done in cycle 28 after the accept edge;
  - gcd=7; error=0.
- a=9, b=9: CMP goes straight to STORE; iter_count=0; done in cycle 4; gcd=9.
- MAX_ITER=8, a=5, b=0: 8 SUBX steps, then ERR; done=1 with error=1 for one cycle; gcd_load never seen; iter_count=8.
- abort asserted in the 3rd SUBX of the 161/14 run: IDLE next cycle; busy=0; no done; iter_count=3. A following start completes normally with gcd=7.
- reset driven low asynchronously between clock edges mid-run: all outputs 0 before the next edge. After release, start with no abort yields a correct run.
- start held high continuously: back-to-back runs each separated by at least one IDLE cycle; start toggling while busy causes no restart or extra LOAD.
